// File: rtl/rs_bank.sv
// Reservation-station bank: buffers dispatched instructions, captures operands from the CDB,
// and offers the oldest operand-complete entry to the functional unit.
module rs_bank #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OP_W        = 32,
  parameter int unsigned NUM_CDB     = 2,
  localparam int unsigned CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      dp_valid,
  output logic                      dp_ready,
  input  logic [OP_W-1:0]           dp_op,
  input  logic [TAG_W-1:0]          dp_rob_tag,
  input  logic                      dp_src1_ready,
  input  logic                      dp_src2_ready,
  input  logic [TAG_W-1:0]          dp_src1_tag,
  input  logic [TAG_W-1:0]          dp_src2_tag,
  input  logic [DATA_W-1:0]         dp_src1_val,
  input  logic [DATA_W-1:0]         dp_src2_val,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_val,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [OP_W-1:0]           iss_op,
  output logic [TAG_W-1:0]          iss_rob_tag,
  output logic [DATA_W-1:0]         iss_v1,
  output logic [DATA_W-1:0]         iss_v2,
  input  logic                      squash,
  output logic [CNT_W-1:0]          free_count
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] busy_q, busy_d, s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
  logic [OP_W-1:0]        op_q     [NUM_ENTRIES];
  logic [OP_W-1:0]        op_d     [NUM_ENTRIES];
  logic [TAG_W-1:0]       rob_q    [NUM_ENTRIES];
  logic [TAG_W-1:0]       rob_d    [NUM_ENTRIES];
  logic [TAG_W-1:0]       s1_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       s1_tag_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       s2_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       s2_tag_d [NUM_ENTRIES];
  logic [DATA_W-1:0]      s1_val_q [NUM_ENTRIES];
  logic [DATA_W-1:0]      s1_val_d [NUM_ENTRIES];
  logic [DATA_W-1:0]      s2_val_q [NUM_ENTRIES];
  logic [DATA_W-1:0]      s2_val_d [NUM_ENTRIES];
  // older_q[i][j] set means entry j is older than entry i.
  logic [NUM_ENTRIES-1:0] older_q  [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] older_d  [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] cand, sel;
  logic [CNT_W-1:0]       free_cnt;
  logic [IDX_W-1:0]       alloc_idx;
  logic                   alloc_en, issue_fire;

  // Returns {hit, value}; the lowest-index matching channel wins.
  function automatic logic [DATA_W:0] cdb_match(input logic [TAG_W-1:0] tag);
    logic [DATA_W:0] res;
    res = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, cdb_val[c*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  always_comb begin
    cand = busy_q & s1_rdy_q & s2_rdy_q;
    sel  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      sel[i] = cand[i] && ((cand & older_q[i]) == '0) && !squash;
    end
  end

  always_comb begin
    iss_op      = '0;
    iss_rob_tag = '0;
    iss_v1      = '0;
    iss_v2      = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sel[i]) begin
        iss_op      = iss_op | op_q[i];
        iss_rob_tag = iss_rob_tag | rob_q[i];
        iss_v1      = iss_v1 | s1_val_q[i];
        iss_v2      = iss_v2 | s2_val_q[i];
      end
    end
  end

  assign iss_valid = |sel;

  always_comb begin
    free_cnt  = '0;
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_cnt  = free_cnt + CNT_W'(1);
        alloc_idx = IDX_W'(i);
      end
    end
  end

  assign free_count = free_cnt;
  assign dp_ready   = (free_cnt != '0) && !squash;
  assign alloc_en   = dp_valid && dp_ready;
  assign issue_fire = iss_valid && iss_ready;

  always_comb begin
    logic [DATA_W:0] m;
    m        = '0;
    busy_d   = busy_q;
    s1_rdy_d = s1_rdy_q;
    s2_rdy_d = s2_rdy_q;
    op_d     = op_q;
    rob_d    = rob_q;
    s1_tag_d = s1_tag_q;
    s2_tag_d = s2_tag_q;
    s1_val_d = s1_val_q;
    s2_val_d = s2_val_q;
    older_d  = older_q;

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (busy_q[i] && !s1_rdy_q[i]) begin
        m = cdb_match(s1_tag_q[i]);
        if (m[DATA_W]) begin
          s1_rdy_d[i] = 1'b1;
          s1_val_d[i] = m[DATA_W-1:0];
        end
      end
      if (busy_q[i] && !s2_rdy_q[i]) begin
        m = cdb_match(s2_tag_q[i]);
        if (m[DATA_W]) begin
          s2_rdy_d[i] = 1'b1;
          s2_val_d[i] = m[DATA_W-1:0];
        end
      end
    end

    if (issue_fire) busy_d = busy_d & ~sel;

    if (alloc_en) begin
      busy_d[alloc_idx] = 1'b1;
      op_d[alloc_idx]   = dp_op;
      rob_d[alloc_idx]  = dp_rob_tag;
      s1_tag_d[alloc_idx] = dp_src1_tag;
      s2_tag_d[alloc_idx] = dp_src2_tag;
      if (dp_src1_ready) begin
        s1_rdy_d[alloc_idx] = 1'b1;
        s1_val_d[alloc_idx] = dp_src1_val;
      end else begin
        m = cdb_match(dp_src1_tag);
        s1_rdy_d[alloc_idx] = m[DATA_W];
        s1_val_d[alloc_idx] = m[DATA_W-1:0];
      end
      if (dp_src2_ready) begin
        s2_rdy_d[alloc_idx] = 1'b1;
        s2_val_d[alloc_idx] = dp_src2_val;
      end else begin
        m = cdb_match(dp_src2_tag);
        s2_rdy_d[alloc_idx] = m[DATA_W];
        s2_val_d[alloc_idx] = m[DATA_W-1:0];
      end
      // New entry is younger than everything; clear its stale column in other rows.
      for (int i = 0; i < NUM_ENTRIES; i++) older_d[i][alloc_idx] = 1'b0;
      older_d[alloc_idx] = busy_q;
    end

    if (squash) busy_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q   <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      op_q     <= '{default: '0};
      rob_q    <= '{default: '0};
      s1_tag_q <= '{default: '0};
      s2_tag_q <= '{default: '0};
      s1_val_q <= '{default: '0};
      s2_val_q <= '{default: '0};
      older_q  <= '{default: '0};
    end else begin
      busy_q   <= busy_d;
      s1_rdy_q <= s1_rdy_d;
      s2_rdy_q <= s2_rdy_d;
      op_q     <= op_d;
      rob_q    <= rob_d;
      s1_tag_q <= s1_tag_d;
      s2_tag_q <= s2_tag_d;
      s1_val_q <= s1_val_d;
      s2_val_q <= s2_val_d;
      older_q  <= older_d;
    end
  end

endmodule

// File: tb/tb_rs_bank.sv
// Self-checking bench for rs_bank: directed scenarios plus random traffic against an
// in-order queue model of the station.
module tb_rs_bank;
  localparam int N  = 8;
  localparam int TW = 5;
  localparam int DW = 32;
  localparam int OW = 32;
  localparam int NC = 2;
  localparam int CW = $clog2(N + 1);

  logic clock, reset;
  logic dp_valid, dp_ready, dp_src1_ready, dp_src2_ready;
  logic [OW-1:0] dp_op;
  logic [TW-1:0] dp_rob_tag, dp_src1_tag, dp_src2_tag;
  logic [DW-1:0] dp_src1_val, dp_src2_val;
  logic [NC-1:0] cdb_valid;
  logic [NC*TW-1:0] cdb_tag;
  logic [NC*DW-1:0] cdb_val;
  logic iss_valid, iss_ready, squash;
  logic [OW-1:0] iss_op;
  logic [TW-1:0] iss_rob_tag;
  logic [DW-1:0] iss_v1, iss_v2;
  logic [CW-1:0] free_count;

  rs_bank #(.NUM_ENTRIES(N), .TAG_W(TW), .DATA_W(DW), .OP_W(OW), .NUM_CDB(NC)) dut (
    .clock(clock), .reset(reset),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_op(dp_op), .dp_rob_tag(dp_rob_tag),
    .dp_src1_ready(dp_src1_ready), .dp_src2_ready(dp_src2_ready),
    .dp_src1_tag(dp_src1_tag), .dp_src2_tag(dp_src2_tag),
    .dp_src1_val(dp_src1_val), .dp_src2_val(dp_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_rob_tag(iss_rob_tag), .iss_v1(iss_v1), .iss_v2(iss_v2),
    .squash(squash), .free_count(free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: queue in age order, index 0 oldest.
  typedef struct {
    logic [OW-1:0] op;
    logic [TW-1:0] tag;
    logic          r1, r2;
    logic [TW-1:0] t1, t2;
    logic [DW-1:0] v1, v2;
  } ent_t;
  ent_t mq[$];

  function automatic bit bus_hit(input logic [TW-1:0] t, output logic [DW-1:0] v);
    for (int c = 0; c < NC; c++) begin
      if (cdb_valid[c] && cdb_tag[c*TW +: TW] == t) begin
        v = cdb_val[c*DW +: DW];
        return 1'b1;
      end
    end
    v = '0;
    return 1'b0;
  endfunction

  function automatic int oldest_ready();
    for (int i = 0; i < mq.size(); i++) if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  task automatic compare_outputs();
    int k;
    ent_t e;
    k = (squash || reset) ? -1 : oldest_ready();
    e = '{default: '0};
    if (k >= 0) e = mq[k];
    check("iss_valid", iss_valid, k >= 0);
    check("iss_op", iss_op, e.op);
    check("iss_rob_tag", iss_rob_tag, e.tag);
    check("iss_v1", iss_v1, e.v1);
    check("iss_v2", iss_v2, e.v2);
    check("free_count", free_count, N - mq.size());
    check("dp_ready", dp_ready, !squash && mq.size() < N);
  endtask

  task automatic update_model();
    int k;
    bit alloc;
    logic [DW-1:0] v;
    ent_t e;
    if (reset || squash) begin
      mq.delete();
      return;
    end
    k = oldest_ready();
    alloc = dp_valid && (mq.size() < N);
    if (k >= 0 && iss_ready) mq.delete(k);
    for (int i = 0; i < mq.size(); i++) begin
      if (!mq[i].r1 && bus_hit(mq[i].t1, v)) begin mq[i].r1 = 1'b1; mq[i].v1 = v; end
      if (!mq[i].r2 && bus_hit(mq[i].t2, v)) begin mq[i].r2 = 1'b1; mq[i].v2 = v; end
    end
    if (alloc) begin
      e.op = dp_op; e.tag = dp_rob_tag; e.t1 = dp_src1_tag; e.t2 = dp_src2_tag;
      e.r1 = dp_src1_ready; e.v1 = dp_src1_val;
      e.r2 = dp_src2_ready; e.v2 = dp_src2_val;
      if (!e.r1 && bus_hit(e.t1, v)) begin e.r1 = 1'b1; e.v1 = v; end
      if (!e.r2 && bus_hit(e.t2, v)) begin e.r2 = 1'b1; e.v2 = v; end
      mq.push_back(e);
    end
  endtask

  // Inputs are set before the call; returns 1 time unit after the next rising edge.
  task automatic cycle();
    @(negedge clock);
    compare_outputs();
    @(posedge clock);
    update_model();
    #1;
  endtask

  task automatic idle();
    dp_valid = 0; dp_op = '0; dp_rob_tag = '0;
    dp_src1_ready = 0; dp_src2_ready = 0; dp_src1_tag = '0; dp_src2_tag = '0;
    dp_src1_val = '0; dp_src2_val = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0; squash = 0;
  endtask

  task automatic disp(input logic [TW-1:0] tag, input logic r1, input logic [TW-1:0] t1,
                      input logic [DW-1:0] v1, input logic r2, input logic [TW-1:0] t2,
                      input logic [DW-1:0] v2);
    dp_valid = 1; dp_op = 32'hC0DE_0000 | 32'(tag); dp_rob_tag = tag;
    dp_src1_ready = r1; dp_src1_tag = t1; dp_src1_val = v1;
    dp_src2_ready = r2; dp_src2_tag = t2; dp_src2_val = v2;
  endtask

  initial begin
    idle();
    iss_ready = 0;
    reset = 1;
    #1;
    check("rst_iss_valid", iss_valid, 0);
    check("rst_free_count", free_count, N);
    check("rst_dp_ready", dp_ready, 1);
    check("rst_iss_op", iss_op, 0);
    cycle();
    reset = 0;
    cycle();

    // Both sources ready: offered next cycle, freed on handshake.
    disp(5'd3, 1, 0, 32'h11, 1, 0, 32'h22);
    cycle();
    idle(); iss_ready = 1; #1;
    check("t1_valid", iss_valid, 1);
    check("t1_tag", iss_rob_tag, 3);
    check("t1_v1", iss_v1, 32'h11);
    check("t1_v2", iss_v2, 32'h22);
    cycle();
    check("t1_free", free_count, N);

    // Age ordering under stall.
    iss_ready = 0;
    for (int i = 5; i <= 7; i++) begin disp(TW'(i), 1, 0, 32'(i), 1, 0, 32'(i * 2)); cycle(); end
    idle();
    for (int i = 0; i < 3; i++) cycle();
    iss_ready = 1;
    for (int i = 5; i <= 7; i++) begin #1; check("t2_order", iss_rob_tag, i); cycle(); end
    check("t2_empty", iss_valid, 0);

    // CDB wakeup on channel 1.
    iss_ready = 0;
    disp(5'd9, 0, 5'd4, 0, 1, 0, 32'h7);
    cycle();
    idle(); cdb_valid = 2'b10; cdb_tag[TW +: TW] = 5'd4; cdb_val[DW +: DW] = 32'hABCD; #1;
    check("t3_waiting", iss_valid, 0);
    cycle();
    idle(); iss_ready = 1; #1;
    check("t3_valid", iss_valid, 1);
    check("t3_v1", iss_v1, 32'hABCD);
    cycle();

    // Dispatch bypass from channel 0.
    disp(5'd13, 0, 5'd12, 0, 1, 0, 32'h1);
    cdb_valid = 2'b01; cdb_tag[0 +: TW] = 5'd12; cdb_val[0 +: DW] = 32'h55;
    cycle();
    idle(); #1;
    check("t4_valid", iss_valid, 1);
    check("t4_v1", iss_v1, 32'h55);
    cycle();

    // Fill, reject ninth, then drain oldest-first.
    for (int i = 0; i < N; i++) begin disp(TW'(10 + i), 0, 5'd1, 0, 1, 0, 32'(i)); cycle(); end
    idle(); #1;
    check("t5_full_ready", dp_ready, 0);
    disp(5'd20, 1, 0, 1, 1, 0, 2);
    cycle();
    idle(); #1;
    check("t5_full_count", free_count, 0);
    cdb_valid = 2'b01; cdb_tag[0 +: TW] = 5'd1; cdb_val[0 +: DW] = 32'h99;
    cycle();
    idle();
    for (int i = 0; i < N; i++) begin #1; check("t5_drain", iss_rob_tag, 10 + i); cycle(); end
    check("t5_free", free_count, N);

    // Squash with a same-cycle dispatch.
    iss_ready = 0;
    for (int i = 0; i < 4; i++) begin disp(TW'(21 + i), 1, 0, 1, 1, 0, 2); cycle(); end
    idle(); #1;
    check("t6_pre_valid", iss_valid, 1);
    squash = 1; disp(5'd25, 1, 0, 1, 1, 0, 2); #1;
    check("t6_sq_valid", iss_valid, 0);
    check("t6_sq_ready", dp_ready, 0);
    cycle();
    idle(); #1;
    check("t6_free", free_count, N);
    check("t6_valid", iss_valid, 0);

    // Reset mid-stall drops the offered entry.
    disp(5'd26, 1, 0, 3, 1, 0, 4);
    cycle();
    idle(); #1;
    check("t7_pre_valid", iss_valid, 1);
    reset = 1; mq.delete(); #1;
    check("t7_rst_valid", iss_valid, 0);
    check("t7_rst_free", free_count, N);
    cycle();
    reset = 0;
    cycle();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      dp_valid = $urandom_range(0, 9) < 6;
      dp_op = $urandom; dp_rob_tag = TW'($urandom);
      dp_src1_ready = $urandom_range(0, 1) == 1; dp_src2_ready = $urandom_range(0, 1) == 1;
      dp_src1_tag = TW'($urandom_range(0, 7)); dp_src2_tag = TW'($urandom_range(0, 7));
      dp_src1_val = $urandom; dp_src2_val = $urandom;
      for (int c = 0; c < NC; c++) begin
        cdb_valid[c] = $urandom_range(0, 1) == 1;
        cdb_tag[c*TW +: TW] = TW'($urandom_range(0, 7));
        cdb_val[c*DW +: DW] = $urandom;
      end
      iss_ready = $urandom_range(0, 9) < 7;
      squash = $urandom_range(0, 49) == 0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
